// File: rtl/sprite_pkg.sv
// Shared register map, control-bit positions and descriptor type for sprite_compositor.
package sprite_pkg;

    localparam logic [1:0] REG_X    = 2'd0;
    localparam logic [1:0] REG_Y    = 2'd1;
    localparam logic [1:0] REG_IMG  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;
    localparam logic [5:0] COLL_ADDR = 6'd63;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_HFLIP_BIT = 1;

    // Image field is sized for the widest select; writes are masked to IMG_W.
    localparam int unsigned IMG_MAX_W = 16;

    typedef struct packed {
        logic [9:0]           x;
        logic [9:0]           y;
        logic [IMG_MAX_W-1:0] img;
        logic                 en;
        logic                 hflip;
    } sprite_regs_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// Avalon-MM slave bus carrying descriptor reads and writes into sprite_compositor.
interface sprite_compositor_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [5:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output chipselect, write, read, address, writedata, input readdata);
    modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/sprite_unit.sv
// One sprite slot: hit test, horizontal flip and pattern-ROM address, registered (stage 1).
module sprite_unit #(
    parameter int unsigned SPRITE_DIM = 32,
    parameter int unsigned IMG_W      = 5,
    parameter int unsigned ROM_AW     = 2 * $clog2(SPRITE_DIM)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [9:0]        col_i,
    input  logic [9:0]        row_i,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    input  logic [IMG_W-1:0]  img_i,
    input  logic              en_i,
    input  logic              hflip_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic [IMG_W-1:0]  rom_img_o,
    output logic              hit_o
);
    localparam int unsigned DW = $clog2(SPRITE_DIM);

    logic [9:0]        dx, dy;
    logic [DW-1:0]     dx_eff;
    logic              hit_d;
    logic [ROM_AW-1:0] addr_d;
    logic [ROM_AW-1:0] addr_q;
    logic [IMG_W-1:0]  img_q;
    logic              hit_q;

    // Negative offsets wrap to large values, so an all-zero upper slice is the in-range test.
    always_comb begin
        dx     = col_i - x_i;
        dy     = row_i - y_i;
        hit_d  = en_i && (dx[9:DW] == '0) && (dy[9:DW] == '0);
        dx_eff = hflip_i ? ~dx[DW-1:0] : dx[DW-1:0];
        addr_d = {dy[DW-1:0], dx_eff};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= '0;
            img_q  <= '0;
            hit_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            img_q  <= img_i;
            hit_q  <= hit_d;
        end
    end

    assign rom_addr_o = addr_q;
    assign rom_img_o  = img_q;
    assign hit_o      = hit_q;
endmodule

// File: rtl/sprite_compositor.sv
// Double-buffered N-slot sprite engine with a fixed 3-cycle pixel pipeline.
// Optional SPRITE_COLLISION_EN adds per-slot collision accumulation readable at address 63.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPRITE_DIM  = 32,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned IMG_W       = 5,
    parameter int unsigned VACTIVE     = 480,
    parameter int unsigned ROM_AW      = 2 * $clog2(SPRITE_DIM)
) (
    input  logic                           clk,
    input  logic                           reset,
    sprite_compositor_if.slave             bus,
    input  logic [10:0]                    hcount,
    input  logic [9:0]                     vcount,
    output logic [NUM_SPRITES*ROM_AW-1:0]  rom_addr,
    output logic [NUM_SPRITES*IMG_W-1:0]   rom_img,
    input  logic [NUM_SPRITES*COLOR_W-1:0] rom_data,
    output logic                           pix_hit,
    output logic [COLOR_W-1:0]             pix_color
);
    localparam int unsigned SW       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [15:0] IMG_MASK = 16'((32'd1 << IMG_W) - 32'd1);
    localparam logic [6:0]  MAP_END  = 7'(4 * NUM_SPRITES);
    localparam logic [9:0]  VACT     = 10'(VACTIVE);

    typedef logic [NUM_SPRITES-1:0] slot_vec_t;

    sprite_regs_t     shadow_q [NUM_SPRITES];
    sprite_regs_t     active_q [NUM_SPRITES];
    logic             commit;
    logic [SW-1:0]    slot;
    logic [1:0]       off;
    logic             in_map;
    logic             wr_en;
    logic [15:0]      rdata_d, rdata_q;
    slot_vec_t        hit_s1, hit_s2_q, opaque;
    logic             pix_hit_d, pix_hit_q;
    logic [COLOR_W-1:0] pix_color_d, pix_color_q;

    assign commit = (vcount == VACT) && (hcount == '0);
    assign slot   = bus.address[2 +: SW];
    assign off    = bus.address[1:0];
    assign in_map = {1'b0, bus.address} < MAP_END;
    assign wr_en  = bus.chipselect && bus.write && in_map;

    // Commit copies the pre-write shadow; a coincident write lands only in shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (commit) begin
                for (int unsigned i = 0; i < NUM_SPRITES; i++) active_q[i] <= shadow_q[i];
            end
            if (wr_en) begin
                case (off)
                    REG_X:    shadow_q[slot].x   <= bus.writedata[9:0];
                    REG_Y:    shadow_q[slot].y   <= bus.writedata[9:0];
                    REG_IMG:  shadow_q[slot].img <= bus.writedata & IMG_MASK;
                    default: begin
                        shadow_q[slot].en    <= bus.writedata[CTRL_EN_BIT];
                        shadow_q[slot].hflip <= bus.writedata[CTRL_HFLIP_BIT];
                    end
                endcase
            end
        end
    end

`ifdef SPRITE_COLLISION_EN
    slot_vec_t coll_now, acc_q, coll_q;

    always_comb begin
        coll_now = '0;
        for (int unsigned k = 0; k < NUM_SPRITES; k++)
            coll_now[k] = opaque[k] && ((opaque & ~(slot_vec_t'(1) << k)) != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            coll_q <= '0;
        end else if (commit) begin
            coll_q <= acc_q;
            acc_q  <= coll_now;
        end else begin
            acc_q  <= acc_q | coll_now;
        end
    end
`endif

    always_comb begin
        rdata_d = '0;
        if (in_map) begin
            case (off)
                REG_X:    rdata_d = {6'b0, shadow_q[slot].x};
                REG_Y:    rdata_d = {6'b0, shadow_q[slot].y};
                REG_IMG:  rdata_d = shadow_q[slot].img;
                default: begin
                    rdata_d[CTRL_EN_BIT]    = shadow_q[slot].en;
                    rdata_d[CTRL_HFLIP_BIT] = shadow_q[slot].hflip;
                end
            endcase
        end
`ifdef SPRITE_COLLISION_EN
        if (bus.address == COLL_ADDR) rdata_d[NUM_SPRITES-1:0] = coll_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)                             rdata_q <= '0;
        else if (bus.chipselect && bus.read)   rdata_q <= rdata_d;
    end

    assign bus.readdata = rdata_q;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_unit
        sprite_unit #(
            .SPRITE_DIM (SPRITE_DIM),
            .IMG_W      (IMG_W),
            .ROM_AW     (ROM_AW)
        ) u_unit (
            .clk_i      (clk),
            .reset_i    (reset),
            .col_i      (hcount[10:1]),
            .row_i      (vcount),
            .x_i        (active_q[g].x),
            .y_i        (active_q[g].y),
            .img_i      (active_q[g].img[IMG_W-1:0]),
            .en_i       (active_q[g].en),
            .hflip_i    (active_q[g].hflip),
            .rom_addr_o (rom_addr[g*ROM_AW +: ROM_AW]),
            .rom_img_o  (rom_img[g*IMG_W +: IMG_W]),
            .hit_o      (hit_s1[g])
        );
    end

    // Hit flags wait one cycle so they line up with the external ROM's registered output.
    always_comb begin
        opaque      = '0;
        pix_hit_d   = 1'b0;
        pix_color_d = '0;
        for (int unsigned k = 0; k < NUM_SPRITES; k++)
            opaque[k] = hit_s2_q[k] && (rom_data[k*COLOR_W +: COLOR_W] != '0);
        for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
            if (opaque[k] && !pix_hit_d) begin
                pix_hit_d   = 1'b1;
                pix_color_d = rom_data[k*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_s2_q    <= '0;
            pix_hit_q   <= 1'b0;
            pix_color_q <= '0;
        end else begin
            hit_s2_q    <= hit_s1;
            pix_hit_q   <= pix_hit_d;
            pix_color_q <= pix_color_d;
        end
    end

    assign pix_hit   = pix_hit_q;
    assign pix_color = pix_color_q;
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised sprite engine that replaces the fixed four-sprite logic in the VGA peripheral. It holds N sprite descriptors written over Avalon-MM, double-buffered so that software updates take effect atomically at the start of vertical blank. For every pixel it produces per-sprite pattern-ROM addresses and a priority-resolved sprite colour index, through a fixed 3-cycle pipeline. It sits between `vga_counters` and the top-level colour mux.

## Interface
Parameters:
- NUM_SPRITES, 4, sprite slots (1–15)
- SPRITE_DIM, 32, sprite edge in pixels; power of two
- COLOR_W, 4, colour-index width; index 0 = transparent
- IMG_W, 5, image-select width
- VACTIVE, 480, visible lines; commit line
- ROM_AW, 2*$clog2(SPRITE_DIM), pattern-ROM address width (derived)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- chipselect, write, read  in  1 each  Avalon-MM strobes
- address  in  6  word address
- writedata  in  16  write data
- readdata  out  16  read data
- hcount  in  11  from vga_counters; column = hcount[10:1]
- vcount  in  10  from vga_counters; row
- rom_addr  out  NUM_SPRITES*ROM_AW  per-sprite pattern address; slot i at [i*ROM_AW +: ROM_AW]
- rom_img  out  NUM_SPRITES*IMG_W  per-sprite image select, used by the top level to steer ROMs
- rom_data  in  NUM_SPRITES*COLOR_W  per-sprite ROM output; one-cycle synchronous read
- pix_hit  out  1  an opaque sprite pixel is present
- pix_color  out  COLOR_W  winning sprite colour index

## Operation
- Register map: slot i base = 4*i.
  - +0: x[9:0], left column.
  - +1: y[9:0], top row.
  - +2: img[IMG_W-1:0].
  - +3: ctrl. bit0 = enable, bit1 = hflip.
  - Addresses at or above 4*NUM_SPRITES, other than 63, ignore writes and read 0.
- Writes go to the shadow set. Shadow is copied to the active set in the cycle where the input vcount == VACTIVE and hcount == 0 (commit). If a write and a commit happen in the same cycle, active takes the pre-write shadow and shadow takes the write.
- Reads of slot registers return shadow values. readdata is registered: valid the cycle after a read with chipselect asserted.
- Hit test for slot i uses active values: enable && (col − x) < SPRITE_DIM && (row − y) < SPRITE_DIM. Subtractions are 10-bit unsigned, so a negative offset wraps and fails the test.
- ROM address = dy*SPRITE_DIM + dx'. dy = row − y. dx' = (col − x), or SPRITE_DIM−1−(col − x) when hflip is set.
- Opaque = hit && rom_data slot ≠ 0. Priority is lowest slot index among opaque slots. If no slot is opaque, pix_hit = 0 and pix_color = 0.
- Reset: shadow and active sets all 0, so every sprite is disabled. rom_addr, rom_img, pix_hit, pix_color, readdata are all 0. Reset asserted mid-frame takes effect on the next edge and abandons any in-flight pixels.

## Timing
- Stage 0 (cycle t): hcount/vcount sampled.
- Stage 1 (t+1): rom_addr, rom_img and registered hit flags valid.
- Stage 2 (t+2): rom_data valid, produced by the external ROM.
- Stage 3 (t+3): pix_hit and pix_color registered for the pixel sampled at t.
- Latency is exactly 3 cycles with no stalls. A new pixel may be presented every cycle.
- The commit takes effect on pixels sampled from t+1 onward.

## Configuration
- SPRITE_COLLISION_EN defined:
  - Per-slot accumulator bit i is set when slot i is opaque in the same pixel as any other opaque slot.
  - At commit, the accumulator is copied to the collision register and cleared. If a collision occurs in the commit cycle itself, it lands in the new accumulator.
  - Address 63 reads the collision register in bits [NUM_SPRITES-1:0].
- Undefined: no accumulator or collision logic; address 63 reads 0.

## Structure
- `sprite_pkg` holds:
  - register offsets (X, Y, IMG, CTRL = 0..3) and COLL_ADDR = 63;
  - the CTRL bit positions;
  - a `sprite_regs_t` struct (x, y, img, en, hflip).
- Sub-module `sprite_unit`, generated NUM_SPRITES times, owns the hit test, hflip and address generation for one slot.
- The top of the block owns the register file, the commit logic, the priority encoder and the collision logic.

## Test plan
- **Single slot:** slot0 x=100, y=50, en=1, wait for commit, ROM returns 3 → pix_hit=1 and pix_color=3 exactly 3 cycles after col 100 row 50; col 132 → pix_hit=0.
- **hflip:** slot0 hflip=1 at col 100 row 50 → rom_addr = 31; col 131 → rom_addr = 0.
- **Atomic update:**
  - Write x=200 mid-frame at row 100 → output still at x=100 for the rest of the frame, x=200 after commit.
  - Write issued in the commit cycle → applied one frame later.
- **Priority:** slots 0 and 2 overlap.
  - Slot0 rom_data 0, slot2 rom_data 5 → pix_color=5.
  - Slot0 rom_data 1 → pix_color=1.
- **Collision (EN):** opaque overlap of slots 1 and 3 in frame N → address 63 reads 0x000A after commit N, then 0x0000 after commit N+1 with no overlap.
- **Reset mid-frame:** assert reset for one cycle → pix_hit=0 and all slots disabled on the next edge; register reads return 0.
